// File: rtl/poly94_sdram_pkg.sv
// Shared types for the Poly94 SDRAM port scheduler: port ids, FSM states and
// the command record captured at grant time.
package poly94_sdram_pkg;

  typedef enum logic [1:0] {
    PORT_VIDEO = 2'd0,
    PORT_CPU   = 2'd1,
    PORT_DMA   = 2'd2
  } port_id_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    REFRESH   = 2'd3
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr_x16;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic        burst;
  } cmd_t;

  localparam logic [7:0] WAIT_MAX = 8'hFF;

  function automatic logic [7:0] wait_next(input logic [7:0] cnt);
    return (cnt == WAIT_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/sdram_port_scheduler_refresh_timer.sv
// Free-running refresh down-counter that raises a pending request at each expiry
// and latches a sticky overrun if the previous refresh was never serviced.
module sdram_refresh_timer
  import poly94_sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic refresh_ack,
  output logic refresh_pending,
  output logic refresh_overrun
);

  localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0] timer_q;

  // An expiry in the same cycle as an ack counts as a fresh request, not an overrun.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q         <= RELOAD;
      refresh_pending <= 1'b0;
      refresh_overrun <= 1'b0;
    end else if (timer_q == '0) begin
      timer_q         <= RELOAD;
      refresh_pending <= 1'b1;
      if (refresh_pending && !refresh_ack) begin
        refresh_overrun <= 1'b1;
      end
    end else begin
      timer_q <= timer_q - 1'b1;
      if (refresh_ack) begin
        refresh_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Three-port SDRAM front end: arbitrates video bursts, CPU and DMA single
// accesses onto one downstream command port, with periodic refresh insertion.
module sdram_port_scheduler
  import poly94_sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 780,
  parameter int STARVE_LIMIT     = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        vid_req_valid,
  output logic        vid_req_ready,
  input  logic [23:0] vid_req_addr_x16,
  output logic        vid_resp_valid,
  output logic        vid_resp_last,
  output logic [15:0] vid_rdata,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_wr,
  input  logic [23:0] cpu_req_addr_x16,
  input  logic [15:0] cpu_req_wdata,
  input  logic [1:0]  cpu_req_wmask,
  output logic        cpu_resp_valid,
  output logic        cpu_resp_last,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req_valid,
  output logic        dma_req_ready,
  input  logic        dma_req_wr,
  input  logic [23:0] dma_req_addr_x16,
  input  logic [15:0] dma_req_wdata,
  input  logic [1:0]  dma_req_wmask,
  output logic        dma_resp_valid,
  output logic        dma_resp_last,
  output logic [15:0] dma_rdata,
  output logic        dn_cmd_valid,
  input  logic        dn_cmd_ready,
  output logic        dn_rd,
  output logic        dn_wr,
  output logic        dn_refresh,
  output logic        dn_burst,
  output logic [23:0] dn_addr_x16,
  output logic [15:0] dn_wdata,
  output logic [1:0]  dn_wmask,
  input  logic        dn_resp_valid,
  input  logic        dn_resp_last,
  input  logic [15:0] dn_rdata,
  output logic        refresh_overrun
);

  localparam logic [7:0] STARVE_TH = (STARVE_LIMIT > 255) ? 8'd255 : 8'(STARVE_LIMIT);

  state_t     state_q, state_d;
  port_id_t   owner_q, grant_port;
  cmd_t       cmd_q, grant_cmd;
  logic       grant_valid, cmd_accept, refresh_ack, refresh_pending;
  logic       busy, in_resp;
  logic [7:0] cpu_wait_q, dma_wait_q;

  sdram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) u_refresh_timer (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .refresh_ack     (refresh_ack),
    .refresh_pending (refresh_pending),
    .refresh_overrun (refresh_overrun)
  );

  // Starvation lifts CPU/DMA above video so a continuous scan-out cannot lock them out.
  always_comb begin
    grant_valid = 1'b1;
    grant_port  = PORT_VIDEO;
    grant_cmd   = '0;
    if (cpu_req_valid && cpu_wait_q >= STARVE_TH)      grant_port = PORT_CPU;
    else if (dma_req_valid && dma_wait_q >= STARVE_TH) grant_port = PORT_DMA;
    else if (vid_req_valid)                            grant_port = PORT_VIDEO;
    else if (cpu_req_valid)                            grant_port = PORT_CPU;
    else if (dma_req_valid)                            grant_port = PORT_DMA;
    else                                               grant_valid = 1'b0;
    case (grant_port)
      PORT_CPU: begin
        grant_cmd.wr       = cpu_req_wr;
        grant_cmd.addr_x16 = cpu_req_addr_x16;
        grant_cmd.wdata    = cpu_req_wdata;
        grant_cmd.wmask    = cpu_req_wmask;
      end
      PORT_DMA: begin
        grant_cmd.wr       = dma_req_wr;
        grant_cmd.addr_x16 = dma_req_addr_x16;
        grant_cmd.wdata    = dma_req_wdata;
        grant_cmd.wmask    = dma_req_wmask;
      end
      default: begin
        grant_cmd.addr_x16 = vid_req_addr_x16;
        grant_cmd.burst    = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_accept  = 1'b0;
    refresh_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (refresh_pending)  state_d = REFRESH;
        else if (grant_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (dn_cmd_ready) begin
          cmd_accept = 1'b1;
          state_d    = cmd_q.wr ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (dn_resp_valid && dn_resp_last) state_d = IDLE;
      end
      REFRESH: begin
        if (dn_cmd_ready) begin
          refresh_ack = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= PORT_VIDEO;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !refresh_pending && grant_valid) begin
        owner_q <= grant_port;
        cmd_q   <= grant_cmd;
      end
    end
  end

  assign busy    = (state_q == ISSUE) || (state_q == WAIT_RESP);
  assign in_resp = (state_q == WAIT_RESP);

  // Waiting is only counted while someone else holds the bus or the arbiter is idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cpu_wait_q <= '0;
      dma_wait_q <= '0;
    end else begin
      if (cpu_req_ready) cpu_wait_q <= '0;
      else if (cpu_req_valid && !(busy && owner_q == PORT_CPU)) cpu_wait_q <= wait_next(cpu_wait_q);
      if (dma_req_ready) dma_wait_q <= '0;
      else if (dma_req_valid && !(busy && owner_q == PORT_DMA)) dma_wait_q <= wait_next(dma_wait_q);
    end
  end

  assign dn_cmd_valid = (state_q == ISSUE) || (state_q == REFRESH);
  assign dn_refresh   = (state_q == REFRESH);
  assign dn_rd        = (state_q == ISSUE) && !cmd_q.wr;
  assign dn_wr        = (state_q == ISSUE) && cmd_q.wr;
  assign dn_burst     = (state_q == ISSUE) && cmd_q.burst;
  assign dn_addr_x16  = cmd_q.addr_x16;
  assign dn_wdata     = cmd_q.wdata;
  assign dn_wmask     = cmd_q.wmask;

  assign vid_req_ready = cmd_accept && owner_q == PORT_VIDEO;
  assign cpu_req_ready = cmd_accept && owner_q == PORT_CPU;
  assign dma_req_ready = cmd_accept && owner_q == PORT_DMA;

  // Read data is steered only to the owner; everyone else sees an idle response bus.
  assign vid_resp_valid = in_resp && owner_q == PORT_VIDEO && dn_resp_valid;
  assign vid_resp_last  = in_resp && owner_q == PORT_VIDEO && dn_resp_last;
  assign vid_rdata      = (in_resp && owner_q == PORT_VIDEO) ? dn_rdata : '0;
  assign cpu_resp_valid = in_resp && owner_q == PORT_CPU && dn_resp_valid;
  assign cpu_resp_last  = in_resp && owner_q == PORT_CPU && dn_resp_last;
  assign cpu_rdata      = (in_resp && owner_q == PORT_CPU) ? dn_rdata : '0;
  assign dma_resp_valid = in_resp && owner_q == PORT_DMA && dn_resp_valid;
  assign dma_resp_last  = in_resp && owner_q == PORT_DMA && dn_resp_last;
  assign dma_rdata      = (in_resp && owner_q == PORT_DMA) ? dn_rdata : '0;

endmodule
